// File: rtl/uart_tx_scheduler.sv
// Arbitrates the shared UART transmitter between the one-shot boot handshake byte
// and the buffered OUT byte stream, driving uart_tx through its start/busy handshake.
module uart_tx_scheduler #(
  parameter int unsigned DEPTH_LOG2 = 11,
  parameter logic [7:0]  BOOT_BYTE  = 8'hAA
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  boot_req,
  output logic                  boot_done,
  input  logic                  wr_valid,
  input  logic [7:0]            wr_data,
  output logic                  wr_ready,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  idle
);

  localparam int unsigned CAP   = 1 << DEPTH_LOG2;
  localparam int unsigned PTR_W = DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_HOLD,
    S_WAIT
  } state_e;

  state_e             state_q;
  logic [7:0]         mem_q [CAP];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [7:0]         rd_data_q;
  logic [7:0]         tx_data_q;
  logic               tx_start_q;
  logic               boot_done_q;
  logic               is_boot_q;

  logic               push_c;
  logic               boot_go_c;
  logic               pop_c;

  assign wr_ready  = !rst && (count_q < CNT_W'(CAP));
  assign push_c    = wr_valid && wr_ready;
  // Boot byte takes priority over queued data whenever both could dispatch.
  assign boot_go_c = (state_q == S_IDLE) && boot_req && !boot_done_q && !tx_busy;
  assign pop_c     = (state_q == S_IDLE) && !boot_go_c && (count_q != '0) && !tx_busy;

  assign boot_done = boot_done_q;
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign count     = count_q;
  assign idle      = (state_q == S_IDLE) && (count_q == '0) && !tx_busy;

  // FIFO storage and registered read port; contents need no reset.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
    if (pop_c) begin
      rd_data_q <= mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      boot_done_q <= 1'b0;
      is_boot_q   <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;

      if (push_c) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end

      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase

      // tx_start is raised on entry to START so it is high for exactly that cycle.
      case (state_q)
        S_IDLE: begin
          if (boot_go_c) begin
            tx_data_q  <= BOOT_BYTE;
            is_boot_q  <= 1'b1;
            tx_start_q <= 1'b1;
            state_q    <= S_START;
          end else if (pop_c) begin
            is_boot_q <= 1'b0;
            state_q   <= S_FETCH;
          end
        end
        S_FETCH: begin
          tx_data_q  <= rd_data_q;
          tx_start_q <= 1'b1;
          state_q    <= S_START;
        end
        S_START: begin
          state_q <= S_HOLD;
        end
        // HOLD masks the cycle before uart_tx has had a chance to raise busy.
        S_HOLD: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (!tx_busy) begin
            state_q <= S_IDLE;
            if (is_boot_q) begin
              boot_done_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomized and directed bench for uart_tx_scheduler against a queue-based
// transaction-timing model, with a small uart_tx responder model.
module tb_uart_tx_scheduler;

  localparam int unsigned DL2 = 2;
  localparam int          CAP = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           boot_req;
  logic           boot_done;
  logic           wr_valid;
  logic [7:0]     wr_data;
  logic           wr_ready;
  logic           tx_busy;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic [DL2:0]   count;
  logic           idle;

  uart_tx_scheduler #(.DEPTH_LOG2(DL2), .BOOT_BYTE(8'hAA)) dut (
    .clk       (clk),
    .rst       (rst),
    .boot_req  (boot_req),
    .boot_done (boot_done),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .count     (count),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // uart_tx responder
  bit  force_busy = 1'b0;
  int  busy_left  = 0;
  int  fmin       = 20;
  int  fmax       = 20;
  byte unsigned sent_q[$];
  int  last_start_cyc = 0;

  // Reference model: byte queue plus the cycle at which the next start is due.
  byte unsigned m_q[$];
  bit  m_boot_done = 1'b0;
  bit  m_inflight  = 1'b0;
  bit  m_is_boot   = 1'b0;
  int  m_start     = 0;
  byte unsigned m_byte = 8'h00;
  byte unsigned m_txd  = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_tests++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp_v, cyc);
    end
  endtask

  function automatic byte unsigned pick(input int i);
    return (i < sent_q.size()) ? sent_q[i] : 8'h00;
  endfunction

  task automatic model_update();
    bit do_push;
    if (rst) begin
      m_q.delete();
      m_boot_done = 1'b0;
      m_inflight  = 1'b0;
      m_txd       = 8'h00;
      busy_left   = 0;
    end else begin
      do_push = wr_valid && (m_q.size() < CAP);
      if (m_inflight) begin
        // Transaction ends once busy is low, no earlier than two cycles after start.
        if (cyc >= m_start + 2 && !tx_busy) begin
          m_inflight = 1'b0;
          if (m_is_boot) m_boot_done = 1'b1;
        end
      end else if (!tx_busy) begin
        if (boot_req && !m_boot_done) begin
          m_inflight = 1'b1;
          m_is_boot  = 1'b1;
          m_start    = cyc + 1;
          m_byte     = 8'hAA;
        end else if (m_q.size() > 0) begin
          m_inflight = 1'b1;
          m_is_boot  = 1'b0;
          m_start    = cyc + 2;
          m_byte     = m_q.pop_front();
        end
      end
      if (m_inflight && m_start == cyc + 1) m_txd = m_byte;
      if (do_push) m_q.push_back(wr_data);
    end
  endtask

  task automatic step();
    @(negedge clk);
    check("tx_start",  32'(tx_start),  32'(m_inflight && (cyc == m_start)));
    check("tx_data",   32'(tx_data),   32'(m_txd));
    check("count",     32'(count),     32'(m_q.size()));
    check("wr_ready",  32'(wr_ready),  32'(!rst && (m_q.size() < CAP)));
    check("boot_done", 32'(boot_done), 32'(m_boot_done));
    check("idle",      32'(idle),      32'(!m_inflight && (m_q.size() == 0) && !tx_busy));
    if (tx_start) begin
      sent_q.push_back(tx_data);
      last_start_cyc = cyc;
      busy_left = int'($urandom_range(fmax, fmin));
    end
    model_update();
    @(posedge clk);
    #1;
    cyc++;
    wr_valid = 1'b0;
    tx_busy  = force_busy || (busy_left > 0);
    if (busy_left > 0) busy_left--;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push_byte(input byte unsigned b);
    wr_valid = 1'b1;
    wr_data  = b;
    step();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    run(n);
    rst = 1'b0;
  endtask

  initial begin
    int push_cyc;
    rst      = 1'b1;
    boot_req = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    tx_busy  = 1'b0;

    do_reset(3);
    check("rst_count", 32'(count), 32'd0);
    check("rst_boot_done", 32'(boot_done), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);

    // Boot handshake, then a second request that must send nothing
    sent_q.delete();
    boot_req = 1'b1;
    run(40);
    boot_req = 1'b0;
    run(3);
    boot_req = 1'b1;
    run(30);
    boot_req = 1'b0;
    check("boot_n", 32'(sent_q.size()), 32'd1);
    check("boot_byte", 32'(pick(0)), 32'hAA);
    check("boot_done_set", 32'(boot_done), 32'd1);

    // Single-byte latency
    run(2);
    sent_q.delete();
    push_cyc = cyc;
    push_byte(8'h41);
    run(10);
    check("lat_n", 32'(sent_q.size()), 32'd1);
    check("lat_cycles", 32'(last_start_cyc - push_cyc), 32'd3);
    check("lat_data", 32'(pick(0)), 32'h41);

    // Burst ordering
    run(30);
    sent_q.delete();
    for (int b = 1; b <= 5; b++) push_byte(8'(b));
    run(150);
    check("burst_n", 32'(sent_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) check("burst_order", 32'(pick(i)), 32'(i + 1));
    check("burst_idle", 32'(idle), 32'd1);

    // Boot vs data arbitration in the same cycle
    do_reset(2);
    sent_q.delete();
    boot_req = 1'b1;
    push_byte(8'h55);
    boot_req = 1'b0;
    run(60);
    check("arb_n", 32'(sent_q.size()), 32'd2);
    check("arb_first", 32'(pick(0)), 32'hAA);
    check("arb_second", 32'(pick(1)), 32'h55);

    // Full FIFO with UART held busy, then wrap
    run(5);
    force_busy = 1'b1;
    step();
    sent_q.delete();
    for (int i = 0; i < 6; i++) push_byte(8'(8'h10 + i));
    check("full_count", 32'(count), 32'd4);
    check("full_ready", 32'(wr_ready), 32'd0);
    force_busy = 1'b0;
    run(120);
    check("full_n", 32'(sent_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) check("full_order", 32'(pick(i)), 32'(8'h10 + i));
    force_busy = 1'b1;
    step();
    sent_q.delete();
    for (int i = 0; i < 4; i++) push_byte(8'(8'h20 + i));
    force_busy = 1'b0;
    run(120);
    check("wrap_n", 32'(sent_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) check("wrap_order", 32'(pick(i)), 32'(8'h20 + i));

    // Reset while waiting on the UART with bytes queued
    push_byte(8'h70);
    run(6);
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    check("mid_count", 32'(count), 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_boot", 32'(boot_done), 32'd0);
    sent_q.delete();
    run(60);
    check("mid_no_tx", 32'(sent_q.size()), 32'd0);

    // Random traffic with variable frame lengths
    fmin = 1;
    fmax = 20;
    for (int i = 0; i < 4000; i++) begin
      wr_valid = ($urandom_range(99, 0) < 35);
      wr_data  = 8'($urandom);
      boot_req = ($urandom_range(99, 0) < 5);
      rst      = ($urandom_range(599, 0) == 0);
      step();
      rst      = 1'b0;
      boot_req = 1'b0;
    end
    run(100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
